// File: rtl/pc_seq_pkg.sv
// Shared types for the program-sequencing unit: next-PC operations and run states.
// Latency: n/a (types and a pure decode helper only).
// Backpressure: n/a.
package pc_seq_pkg;

    // Next-PC operation; raw encodings 5..7 are not listed and decode as PC_INC.
    typedef enum logic [2:0] {
        PC_INC  = 3'd0,
        PC_BR   = 3'd1,
        PC_JMP  = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_op_e;

    // Run/halt sequencing state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Map the raw 3-bit op field onto the enum, folding reserved codes to PC_INC.
    function automatic pc_op_e decode_op(input logic [2:0] raw);
        pc_op_e op;
        case (raw)
            3'd1:    op = PC_BR;
            3'd2:    op = PC_JMP;
            3'd3:    op = PC_CALL;
            3'd4:    op = PC_RET;
            default: op = PC_INC;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Control/status bundle between the fetch controller and pc_seq_unit.
// Latency: n/a (wiring only); all status fields are registered inside the unit.
// Backpressure: stall is the only hold-off; there is no ready/valid on this bundle.
interface pc_seq_unit_if #(
    parameter int AW    = 12,
    parameter int OFF_W = 8
);
    logic             start;
    logic             done;
    logic             stall;
    logic [2:0]       op;
    logic             cond;
    logic [OFF_W-1:0] offset;
    logic [AW-1:0]    target;
    logic [AW-1:0]    pc_out;
    logic             running;
    logic             halted;
    logic             ras_ovf;
    logic             ras_unf;

    // Controller side: drives control, observes PC and status.
    modport master (
        output start, done, stall, op, cond, offset, target,
        input  pc_out, running, halted, ras_ovf, ras_unf
    );

    // Sequencer side: consumes control, produces PC and status.
    modport slave (
        input  start, done, stall, op, cond, offset, target,
        output pc_out, running, halted, ras_ovf, ras_unf
    );

endinterface

// File: rtl/pc_seq_unit_ras.sv
// Bounded return-address LIFO; push when full and pop when empty are ignored.
// Latency: push/pop/clr take effect on the next edge; dout shows the current top combinationally from storage.
// Backpressure: none; full/empty are reported so the caller can flag dropped operations.
module pc_ras #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    // Pointer counts occupancy 0..DEPTH; index width only needs to address DEPTH slots.
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign full   = (ptr == PW'(DEPTH));
    assign empty  = (ptr == '0);
    assign top    = ptr - PW'(1);
    assign wr_idx = ptr[IW-1:0];
    assign rd_idx = top[IW-1:0];
    assign dout   = mem[rd_idx];

    // Pointer and storage update; clear wins, overfull pushes and empty pops are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            ptr <= '0;
        end else if (push && !full) begin
            mem[wr_idx] <= din;
            ptr         <= ptr + PW'(1);
        end else if (pop && !empty) begin
            ptr <= top;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage PC sequencer: INC/BR/JMP/CALL/RET next-PC select gated by an IDLE/RUN/HALT machine.
// Latency: 1 cycle from op sample to pc_out; every output is a register.
// Backpressure: stall holds PC, RAS and flags in RUN; done (higher priority) halts the run.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int            AW         = 12,
    parameter int            OFF_W      = 8,
    parameter int            RAS_DEPTH  = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic         clk,
    input  logic         reset,
    pc_seq_unit_if.slave bus
);
    pc_state_e               state;
    logic [AW-1:0]           pc_q;
    logic [AW-1:0]           pc_nxt;
    logic [AW-1:0]           pc_inc;
    logic [AW-1:0]           ras_dout;
    logic signed [OFF_W-1:0] off_s;
    pc_op_e                  op_d;
    logic                    advance;
    logic                    begin_run;
    logic                    ras_push;
    logic                    ras_pop;
    logic                    ras_full;
    logic                    ras_empty;
    logic                    running_q;
    logic                    halted_q;
    logic                    ovf_q;
    logic                    unf_q;

    // PC only advances in RUN with neither done nor stall; a run (re)starts from IDLE or HALT.
    assign advance   = (state == RUN) && !bus.done && !bus.stall;
    assign begin_run = (state != RUN) && bus.start;
    assign op_d      = decode_op(bus.op);
    assign off_s     = bus.offset;
    assign pc_inc    = pc_q + AW'(1);
    assign ras_push  = advance && (op_d == PC_CALL);
    assign ras_pop   = advance && (op_d == PC_RET);

    // Return stack; the return address pushed by CALL is the instruction after the call.
    pc_ras #(
        .W     (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .clr   (begin_run),
        .din   (pc_inc),
        .dout  (ras_dout),
        .full  (ras_full),
        .empty (ras_empty)
    );

    // Next-PC select; all sums wrap silently at AW bits, an empty-stack RET falls through.
    always_comb begin
        pc_nxt = pc_inc;
        case (op_d)
            PC_BR:   pc_nxt = bus.cond ? (pc_q + AW'(off_s)) : pc_inc;
            PC_JMP:  pc_nxt = bus.target;
            PC_CALL: pc_nxt = bus.target;
            PC_RET:  pc_nxt = ras_empty ? pc_inc : ras_dout;
            default: pc_nxt = pc_inc;
        endcase
    end

    // Run/halt machine with registered status, PC register and sticky stack flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= RESET_ADDR;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.done) begin
                        state     <= HALT;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end else if (!bus.stall) begin
                        pc_q <= pc_nxt;
                        if (ras_push && ras_full) begin
                            ovf_q <= 1'b1;
                        end
                        if (ras_pop && ras_empty) begin
                            unf_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.start) begin
                        state     <= RUN;
                        pc_q      <= RESET_ADDR;
                        running_q <= 1'b1;
                        halted_q  <= 1'b0;
                        ovf_q     <= 1'b0;
                        unf_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.pc_out  = pc_q;
    assign bus.running = running_q;
    assign bus.halted  = halted_q;
    assign bus.ras_ovf = ovf_q;
    assign bus.ras_unf = unf_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model result for inputs applied before edge N is compared 1 time unit after edge N.
// Backpressure: stall/done are exercised both directed and at random.
module tb_pc_seq_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_seq_unit_if #(.AW(12), .OFF_W(8)) bus ();

    pc_seq_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: state 0 idle / 1 run / 2 halt, the stack is a plain queue.
    int m_state;
    int m_pc;
    int m_ras[$];
    int m_ovf;
    int m_unf;

    // Compare one observed value with its expected value.
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_ras.delete();
        m_ovf   = 0;
        m_unf   = 0;
    endtask

    // One clock edge of behaviour, straight from the operational rules.
    task automatic model_step(input bit s, input bit d, input bit st, input int o,
                              input bit c, input int off, input int tgt);
        int so;
        if (m_state != 1) begin
            if (s) begin
                m_state = 1;
                m_pc    = 0;
                m_ras.delete();
                m_ovf   = 0;
                m_unf   = 0;
            end
        end else if (d) begin
            m_state = 2;
        end else if (!st) begin
            so = (off >= 128) ? off - 256 : off;
            case (o)
                1: m_pc = c ? m_pc + so : m_pc + 1;
                2: m_pc = tgt;
                3: begin
                    if (m_ras.size() < 4) m_ras.push_back((m_pc + 1) & 'hFFF);
                    else m_ovf = 1;
                    m_pc = tgt;
                end
                4: begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin
                        m_pc  = m_pc + 1;
                        m_unf = 1;
                    end
                end
                default: m_pc = m_pc + 1;
            endcase
            m_pc = m_pc & 'hFFF;
        end
    endtask

    task automatic compare_model();
        chk("pc_out",  int'(bus.pc_out),  m_pc);
        chk("running", int'(bus.running), int'(m_state == 1));
        chk("halted",  int'(bus.halted),  int'(m_state == 2));
        chk("ras_ovf", int'(bus.ras_ovf), m_ovf);
        chk("ras_unf", int'(bus.ras_unf), m_unf);
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic cyc(input bit s, input bit d, input bit st, input int o,
                       input bit c, input int off, input int tgt);
        bus.start  = s;
        bus.done   = d;
        bus.stall  = st;
        bus.op     = 3'(o);
        bus.cond   = c;
        bus.offset = 8'(off);
        bus.target = 12'(tgt);
        model_step(s, d, st, o, c, off, tgt);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic run_op(input int o, input bit c, input int off, input int tgt);
        cyc(1'b0, 1'b0, 1'b0, o, c, off, tgt);
    endtask

    // Asynchronous reset pulse placed between clock edges; outputs must clear without an edge.
    task automatic mid_reset();
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        chk("areset_pc",  int'(bus.pc_out), 0);
        chk("areset_run", int'(bus.running), 0);
        chk("areset_hlt", int'(bus.halted), 0);
        chk("areset_flg", int'({bus.ras_ovf, bus.ras_unf}), 0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.done = 1'b0; bus.stall = 1'b0; bus.op = 3'd0;
        bus.cond = 1'b0; bus.offset = '0; bus.target = '0;
        model_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #3;
        chk("rst_pc",      int'(bus.pc_out), 'h000);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_halted",  int'(bus.halted), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Idle: no start, PC stays put.
        for (int i = 0; i < 5; i++) run_op(0, 0, 0, 0);
        chk("idle_pc", int'(bus.pc_out), 'h000);
        chk("idle_running", int'(bus.running), 0);

        // Start, then increment across the wrap point.
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        chk("start_running", int'(bus.running), 1);
        run_op(2, 0, 0, 'hFFE);
        run_op(0, 0, 0, 0); chk("inc_fff", int'(bus.pc_out), 'hFFF);
        run_op(0, 0, 0, 0); chk("inc_000", int'(bus.pc_out), 'h000);
        run_op(0, 0, 0, 0); chk("inc_001", int'(bus.pc_out), 'h001);

        // Branch taken backwards, branch not taken, stalled jump.
        run_op(2, 0, 0, 'h010);
        run_op(1, 1, 'hF8, 0); chk("br_taken", int'(bus.pc_out), 'h008);
        run_op(2, 0, 0, 'h010);
        run_op(1, 0, 'hF8, 0); chk("br_not", int'(bus.pc_out), 'h011);
        cyc(1'b0, 1'b0, 1'b1, 2, 0, 0, 'h300); chk("stall1", int'(bus.pc_out), 'h011);
        cyc(1'b0, 1'b0, 1'b1, 2, 0, 0, 'h300); chk("stall2", int'(bus.pc_out), 'h011);
        run_op(2, 0, 0, 'h300); chk("stall_rel", int'(bus.pc_out), 'h300);

        // Nested call/return, back-to-back.
        run_op(2, 0, 0, 'h020);
        run_op(3, 0, 0, 'h100); chk("call1", int'(bus.pc_out), 'h100);
        run_op(3, 0, 0, 'h200); chk("call2", int'(bus.pc_out), 'h200);
        run_op(4, 0, 0, 0);     chk("ret1",  int'(bus.pc_out), 'h101);
        run_op(4, 0, 0, 0);     chk("ret2",  int'(bus.pc_out), 'h021);

        // Overflow on the fifth call, underflow on the fifth return.
        run_op(2, 0, 0, 'h080);
        for (int i = 0; i < 5; i++) begin
            run_op(3, 0, 0, 'h400 + 'h10 * i);
            if (i == 3) chk("ovf_before", int'(bus.ras_ovf), 0);
        end
        chk("ovf_set", int'(bus.ras_ovf), 1);
        for (int i = 0; i < 5; i++) begin
            run_op(4, 0, 0, 0);
            if (i == 3) begin
                chk("unf_before", int'(bus.ras_unf), 0);
                chk("ret4_pc", int'(bus.pc_out), 'h081);
            end
        end
        chk("unf_set", int'(bus.ras_unf), 1);
        chk("unf_pc", int'(bus.pc_out), 'h082);

        // Done wins over the jump; then restart clears everything.
        cyc(1'b0, 1'b1, 1'b0, 2, 0, 0, 'h555);
        chk("halt_flag", int'(bus.halted), 1);
        chk("halt_pc", int'(bus.pc_out), 'h082);
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        chk("restart_pc", int'(bus.pc_out), 'h000);
        chk("restart_run", int'(bus.running), 1);
        chk("restart_flags", int'({bus.ras_ovf, bus.ras_unf}), 0);

        // Reset with two stacked entries; the stack must come back empty.
        run_op(3, 0, 0, 'h010);
        run_op(3, 0, 0, 'h020);
        mid_reset();
        cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        run_op(4, 0, 0, 0);
        chk("post_rst_unf", int'(bus.ras_unf), 1);
        chk("post_rst_pc", int'(bus.pc_out), 'h001);

        // Randomized traffic, including reserved op codes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) mid_reset();
            else cyc($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 4) == 0, int'($urandom_range(0, 7)),
                     $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 4095)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
